// File: rtl/ws2812b_receiver.sv
// ws2812b_receiver
// Decodes a WS2812B single-wire waveform. Each bit is classified by the width
// of its high pulse, bits are packed LSB first into WIDTH-bit pixel words, and
// a long low interval is reported as the end-of-frame latch gap.
//
// Ports:
//   clk          system clock (50 MHz nominal)
//   rst_n        asynchronous active-low reset
//   wave_in      serial line, asynchronous to clk
//   data_out     last completed pixel word, bit k = k-th received bit
//   data_valid   one-cycle pulse when data_out is updated
//   pixel_index  position of data_out's word within the current frame
//   latch        one-cycle pulse when the reset gap is detected
//   bit_error    one-cycle pulse on glitch, over-long high, or partial word at latch
`timescale 1ns/1ps
module ws2812b_receiver #(
    parameter int WIDTH        = 24,
    parameter int THRESH       = 30,
    parameter int MIN_HIGH     = 5,
    parameter int MAX_HIGH     = 100,
    parameter int RESET_CYCLES = 2500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wave_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic [7:0]       pixel_index,
    output logic             latch,
    output logic             bit_error
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int HW = $clog2(MAX_HIGH + 1);
    localparam int LW = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state;
    logic             sync1, sync2, sync3;
    logic [1:0]       sample_vld;
    logic             armed;
    logic [HW-1:0]    high_cnt;
    logic [LW-1:0]    low_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [7:0]       word_cnt;
    logic [WIDTH-1:0] shift_reg;

    logic             rise, fall;
    logic             bit_ok;
    logic             bit_val;
    logic [WIDTH-1:0] asm_word;

    // Two-flop synchronizer plus a history flop for edge detection.
    // sample_vld marks when sync2 carries a real line sample rather than the
    // reset value, so a line already high at release is not seen as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            sample_vld <= 2'b00;
        end else begin
            sync1      <= wave_in;
            sync2      <= sync1;
            sync3      <= sync2;
            sample_vld <= {sample_vld[0], 1'b1};
        end
    end

    assign rise = sync2 & ~sync3;
    assign fall = ~sync2 & sync3;

    // Classification of the bit that ends on the current falling edge, and
    // the word as it would look with that bit inserted at bit_cnt.
    always_comb begin
        bit_ok            = (high_cnt >= HW'(MIN_HIGH)) && (high_cnt < HW'(MAX_HIGH));
        bit_val           = (high_cnt >= HW'(THRESH));
        asm_word          = shift_reg;
        asm_word[bit_cnt] = bit_val;
    end

    // Decoder FSM. Pulse outputs default low every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            armed       <= 1'b0;
            high_cnt    <= '0;
            low_cnt     <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            shift_reg   <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            pixel_index <= '0;
            latch       <= 1'b0;
            bit_error   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            latch      <= 1'b0;
            bit_error  <= 1'b0;

            // Decoding may only start once a genuine low has been observed.
            if (state == IDLE && sample_vld[1] && !sync2) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rise && armed) begin
                        state    <= HIGH;
                        high_cnt <= HW'(1);
                    end
                end

                HIGH: begin
                    if (fall) begin
                        state   <= LOW;
                        low_cnt <= LW'(1);
                        if (bit_ok) begin
                            shift_reg <= asm_word;
                            if (bit_cnt == BW'(WIDTH - 1)) begin
                                data_out    <= asm_word;
                                data_valid  <= 1'b1;
                                pixel_index <= word_cnt;
                                word_cnt    <= word_cnt + 8'd1;
                                bit_cnt     <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            bit_error <= 1'b1;
                        end
                    end else if (high_cnt < HW'(MAX_HIGH)) begin
                        high_cnt <= high_cnt + HW'(1);
                    end
                end

                LOW: begin
                    if (rise) begin
                        state    <= HIGH;
                        high_cnt <= HW'(1);
                    end else if (low_cnt >= LW'(RESET_CYCLES - 1)) begin
                        // This cycle brings the low count to the full gap.
                        state     <= IDLE;
                        low_cnt   <= LW'(RESET_CYCLES);
                        latch     <= 1'b1;
                        bit_error <= (bit_cnt != '0);
                        bit_cnt   <= '0;
                        word_cnt  <= '0;
                    end else begin
                        low_cnt <= low_cnt + LW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_receiver.sv
`timescale 1ns/1ps
module tb_ws2812b_receiver;

    logic        clk;
    logic        rst_n;
    logic        wave_in;
    logic [23:0] data_out;
    logic        data_valid;
    logic [7:0]  pixel_index;
    logic        latch;
    logic        bit_error;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fall_cyc = 0;

    logic [23:0] dv_data[$];
    logic [7:0]  dv_idx[$];
    int          dv_cyc[$];
    int          lt_cyc[$];
    logic        lt_err[$];
    int          be_cnt  = 0;
    int          overlap = 0;

    ws2812b_receiver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wave_in     (wave_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .pixel_index (pixel_index),
        .latch       (latch),
        .bit_error   (bit_error)
    );

    // 100 MHz simulation clock; only cycle counts matter to the decoder.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (data_valid) begin
            dv_data.push_back(data_out);
            dv_idx.push_back(pixel_index);
            dv_cyc.push_back(cyc);
        end
        if (latch) begin
            lt_cyc.push_back(cyc);
            lt_err.push_back(bit_error);
        end
        if (bit_error) be_cnt++;
        if (data_valid && (bit_error || latch)) overlap++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One bit: high for h cycles then low for l cycles; starts on a negedge.
    task automatic applyStimulus(input int h, input int l);
        wave_in = 1'b1;
        repeat (h) @(negedge clk);
        wave_in  = 1'b0;
        fall_cyc = cyc;
        repeat (l) @(negedge clk);
    endtask

    task automatic sendWord(input logic [23:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (w[i]) applyStimulus(40, 20);
            else      applyStimulus(20, 40);
        end
    endtask

    int dv0, lt0, be0;

    initial begin
        rst_n   = 1'b0;
        wave_in = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_data_out",    32'(data_out),    32'h0);
        checkOutput("reset_data_valid",  32'(data_valid),  32'h0);
        checkOutput("reset_pixel_index", 32'(pixel_index), 32'h0);
        checkOutput("reset_latch",       32'(latch),       32'h0);
        checkOutput("reset_bit_error",   32'(bit_error),   32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single pixel
        dv0 = dv_data.size();
        sendWord(24'h00FF55, 24);
        checkOutput("p1_count", 32'(dv_data.size() - dv0), 32'd1);
        checkOutput("p1_data",  32'(dv_data[dv0]), 32'h00FF55);
        checkOutput("p1_index", 32'(dv_idx[dv0]),  32'd0);
        checkOutput("p1_latency", 32'(dv_cyc[dv0] - fall_cyc), 32'd3);
        lt0 = lt_cyc.size();
        repeat (2600) @(negedge clk);
        checkOutput("p1_latch_count", 32'(lt_cyc.size() - lt0), 32'd1);

        // Two-pixel frame with end-of-frame gap
        dv0 = dv_data.size();
        lt0 = lt_cyc.size();
        be0 = be_cnt;
        sendWord(24'h123456, 24);
        sendWord(24'hABCDEF, 24);
        repeat (2600) @(negedge clk);
        checkOutput("f_count",  32'(dv_data.size() - dv0), 32'd2);
        checkOutput("f_data0",  32'(dv_data[dv0]),     32'h123456);
        checkOutput("f_index0", 32'(dv_idx[dv0]),      32'd0);
        checkOutput("f_data1",  32'(dv_data[dv0 + 1]), 32'hABCDEF);
        checkOutput("f_index1", 32'(dv_idx[dv0 + 1]),  32'd1);
        checkOutput("f_latch_count", 32'(lt_cyc.size() - lt0), 32'd1);
        checkOutput("f_latch_delay", 32'(lt_cyc[lt0] - fall_cyc), 32'd2502);
        checkOutput("f_latch_err", 32'(lt_err[lt0]), 32'd0);
        checkOutput("f_no_error", 32'(be_cnt - be0), 32'd0);

        // Threshold boundary: even bits 29 high (0), odd bits 30 high (1)
        dv0 = dv_data.size();
        for (int i = 0; i < 24; i++) begin
            applyStimulus((i % 2 == 1) ? 30 : 29, 30);
        end
        checkOutput("thr_data",  32'(dv_data[dv0]), 32'hAAAAAA);
        checkOutput("thr_index", 32'(dv_idx[dv0]),  32'd0);

        // Glitch inserted after bit 7
        dv0 = dv_data.size();
        be0 = be_cnt;
        sendWord(24'h5A5A5A, 8);
        applyStimulus(3, 20);
        sendWord(24'h5A5A5A >> 8, 16);
        checkOutput("gl_error", 32'(be_cnt - be0), 32'd1);
        checkOutput("gl_data",  32'(dv_data[dv0]), 32'h5A5A5A);
        checkOutput("gl_index", 32'(dv_idx[dv0]),  32'd1);

        // Over-long high inserted after bit 3
        dv0 = dv_data.size();
        be0 = be_cnt;
        sendWord(24'h0F0F0F, 4);
        applyStimulus(150, 40);
        sendWord(24'h0F0F0F >> 4, 20);
        checkOutput("ol_error", 32'(be_cnt - be0), 32'd1);
        checkOutput("ol_data",  32'(dv_data[dv0]), 32'h0F0F0F);
        checkOutput("ol_index", 32'(dv_idx[dv0]),  32'd2);
        lt0 = lt_cyc.size();
        repeat (2600) @(negedge clk);
        checkOutput("ol_latch_count", 32'(lt_cyc.size() - lt0), 32'd1);
        checkOutput("ol_latch_err", 32'(lt_err[lt0]), 32'd0);

        // Partial word at latch
        dv0 = dv_data.size();
        lt0 = lt_cyc.size();
        be0 = be_cnt;
        sendWord(24'h0003FF, 10);
        repeat (2600) @(negedge clk);
        checkOutput("pw_latch_count", 32'(lt_cyc.size() - lt0), 32'd1);
        checkOutput("pw_latch_err", 32'(lt_err[lt0]), 32'd1);
        checkOutput("pw_error_count", 32'(be_cnt - be0), 32'd1);
        checkOutput("pw_no_valid", 32'(dv_data.size() - dv0), 32'd0);
        sendWord(24'hC3A5F0, 24);
        checkOutput("pw_next_data",  32'(dv_data[dv0]), 32'hC3A5F0);
        checkOutput("pw_next_index", 32'(dv_idx[dv0]),  32'd0);

        // Asynchronous reset in the middle of word 2
        sendWord(24'h111111, 24);
        sendWord(24'h00001F, 5);
        dv0 = dv_data.size();
        lt0 = lt_cyc.size();
        be0 = be_cnt;
        wave_in = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        checkOutput("pre_rst_data",  32'(data_out),    32'h111111);
        checkOutput("pre_rst_index", 32'(pixel_index), 32'd1);
        rst_n = 1'b0;
        #0.5;
        checkOutput("rst_data_out",    32'(data_out),    32'h0);
        checkOutput("rst_data_valid",  32'(data_valid),  32'h0);
        checkOutput("rst_pixel_index", 32'(pixel_index), 32'h0);
        checkOutput("rst_latch",       32'(latch),       32'h0);
        checkOutput("rst_bit_error",   32'(bit_error),   32'h0);
        #0.5;
        rst_n = 1'b1;
        @(negedge clk);
        repeat (30) @(negedge clk);
        wave_in = 1'b0;
        repeat (40) @(negedge clk);
        sendWord(24'h2468AC, 24);
        checkOutput("ar_count", 32'(dv_data.size() - dv0), 32'd1);
        checkOutput("ar_data",  32'(dv_data[dv0]), 32'h2468AC);
        checkOutput("ar_index", 32'(dv_idx[dv0]),  32'd0);
        checkOutput("ar_no_error", 32'(be_cnt - be0), 32'd0);
        checkOutput("ar_no_latch", 32'(lt_cyc.size() - lt0), 32'd0);

        checkOutput("pulse_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
